// File: rtl/fpu_op_scheduler.sv
// ============================================================================
// fpu_op_scheduler
//
// Shares one set of FPU execution units (F32 add/sub, mul, div, F32->INT,
// INT->F32) among REQ_COUNT requesters. Each cycle at most one request is
// granted round-robin. The grant is forwarded to the matching unit. A
// writeback slot is reserved for the cycle the unit will finish. This keeps
// two units from completing in the same cycle, so a single registered
// response port can return every result tagged with its requester ID.
//
// Ports
//   MCLK        clock
//   RST         synchronous active-high reset
//   REQ_VALID   per-requester request valid
//   REQ_READY   per-requester accept (combinational, one-hot or zero)
//   REQ_OP      3 bits per requester: 0 ADD 1 SUB 2 MUL 3 DIV 4 F2I 5 I2F
//   REQ_A/B     32-bit operands per requester
//   U_EN        one-hot unit strobe: bit0 ADD 1 MUL 2 DIV 3 F2I 4 I2F
//   U_A/U_B     issued operands (SUB flips the sign of B on the ADD unit)
//   U_RES_*     unit result buses, sampled in the reserved writeback cycle
//   RSP_VALID   one-cycle response pulse
//   RSP_ID      requester index of the response
//   RSP_DATA    result (0x7FC00000 for illegal opcodes)
//   RSP_ERR     illegal-opcode flag
//   BUSY        any op in flight, divider occupied, or response pending
// ============================================================================
module fpu_op_scheduler #(
    parameter int REQ_COUNT = 4,
    parameter int LAT_ADD   = 3,
    parameter int LAT_MUL   = 3,
    parameter int LAT_DIV   = 12,
    parameter int LAT_CVT   = 2
) (
    input  logic                          MCLK,
    input  logic                          RST,
    input  logic [REQ_COUNT-1:0]          REQ_VALID,
    output logic [REQ_COUNT-1:0]          REQ_READY,
    input  logic [3*REQ_COUNT-1:0]        REQ_OP,
    input  logic [32*REQ_COUNT-1:0]       REQ_A,
    input  logic [32*REQ_COUNT-1:0]       REQ_B,
    output logic [4:0]                    U_EN,
    output logic [31:0]                   U_A,
    output logic [31:0]                   U_B,
    input  logic [31:0]                   U_RES_ADD,
    input  logic [31:0]                   U_RES_MUL,
    input  logic [31:0]                   U_RES_DIV,
    input  logic [31:0]                   U_RES_F2I,
    input  logic [31:0]                   U_RES_I2F,
    output logic                          RSP_VALID,
    output logic [$clog2(REQ_COUNT)-1:0]  RSP_ID,
    output logic [31:0]                   RSP_DATA,
    output logic                          RSP_ERR,
    output logic                          BUSY
);

    localparam int ID_W   = $clog2(REQ_COUNT);
    localparam int MAX_AM = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int MAX_DC = (LAT_DIV > LAT_CVT) ? LAT_DIV : LAT_CVT;
    localparam int DEPTH  = (MAX_AM > MAX_DC) ? MAX_AM : MAX_DC;
    localparam int DIV_W  = $clog2(LAT_DIV + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_F2I = 3'd4;
    localparam logic [2:0] OP_I2F = 3'd5;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        UNIT_ADD  = 3'd0,
        UNIT_MUL  = 3'd1,
        UNIT_DIV  = 3'd2,
        UNIT_F2I  = 3'd3,
        UNIT_I2F  = 3'd4,
        UNIT_NONE = 3'd5
    } unit_t;

    // One writeback reservation; slots[k] completes k cycles from now.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        unit_t           unit;
        logic            err;
    } slot_t;

    function automatic int op_lat(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB: return LAT_ADD;
            OP_MUL:         return LAT_MUL;
            OP_DIV:         return LAT_DIV;
            OP_F2I, OP_I2F: return LAT_CVT;
            default:        return 1;
        endcase
    endfunction

    function automatic unit_t op_unit(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB: return UNIT_ADD;
            OP_MUL:         return UNIT_MUL;
            OP_DIV:         return UNIT_DIV;
            OP_F2I:         return UNIT_F2I;
            OP_I2F:         return UNIT_I2F;
            default:        return UNIT_NONE;
        endcase
    endfunction

    slot_t                slots [DEPTH];
    logic [DEPTH-1:0]     slot_busy;
    logic [ID_W-1:0]      rr_ptr;
    logic [DIV_W-1:0]     div_cnt;
    logic [REQ_COUNT-1:0] req_ok;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    int                   scan_idx;
    logic [2:0]           g_op;
    logic [31:0]          g_a;
    logic [31:0]          g_b;
    int                   g_lat;
    slot_t                new_entry;
    logic [31:0]          res_sel;

    // NOTE: every variable driven from always_comb is given a default on
    // entry; a path that leaves one unassigned would infer a latch.
    always_comb begin
        slot_busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_busy[k] = slots[k].valid;
        end
    end

    // A request is issuable when its completion slot is free; offsets at or
    // beyond DEPTH are never occupied. The divider is not pipelined.
    always_comb begin
        req_ok = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            logic [2:0] op;
            logic       free;
            op   = REQ_OP[3*i +: 3];
            free = 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                if (k == op_lat(op) && slot_busy[k]) begin
                    free = 1'b0;
                end
            end
            if (op == OP_DIV && div_cnt != '0) begin
                free = 1'b0;
            end
            req_ok[i] = REQ_VALID[i] && free;
        end
    end

    // Round-robin scan from rr_ptr; blocked requesters are skipped.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            scan_idx = (int'(rr_ptr) + i) % REQ_COUNT;
            if (!grant_valid && req_ok[scan_idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        g_op = '0;
        g_a  = '0;
        g_b  = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (ID_W'(i) == grant_id) begin
                g_op = REQ_OP[3*i +: 3];
                g_a  = REQ_A[32*i +: 32];
                g_b  = REQ_B[32*i +: 32];
            end
        end
        g_lat = op_lat(g_op);
        new_entry.valid = 1'b1;
        new_entry.id    = grant_id;
        new_entry.unit  = op_unit(g_op);
        new_entry.err   = (op_unit(g_op) == UNIT_NONE);
    end

    // Issue-side outputs are combinational and forced low during reset.
    always_comb begin
        REQ_READY = '0;
        U_EN      = '0;
        U_A       = '0;
        U_B       = '0;
        if (!RST && grant_valid) begin
            REQ_READY[grant_id] = 1'b1;
            U_A = g_a;
            U_B = (g_op == OP_SUB) ? {~g_b[31], g_b[30:0]} : g_b;
            case (op_unit(g_op))
                UNIT_ADD: U_EN = 5'b00001;
                UNIT_MUL: U_EN = 5'b00010;
                UNIT_DIV: U_EN = 5'b00100;
                UNIT_F2I: U_EN = 5'b01000;
                UNIT_I2F: U_EN = 5'b10000;
                default:  U_EN = 5'b00000;
            endcase
        end
    end

    always_comb begin
        res_sel = QNAN;
        if (!slots[0].err) begin
            case (slots[0].unit)
                UNIT_ADD: res_sel = U_RES_ADD;
                UNIT_MUL: res_sel = U_RES_MUL;
                UNIT_DIV: res_sel = U_RES_DIV;
                UNIT_F2I: res_sel = U_RES_F2I;
                UNIT_I2F: res_sel = U_RES_I2F;
                default:  res_sel = QNAN;
            endcase
        end
    end

    assign BUSY = (|slot_busy) || (div_cnt != '0) || RSP_VALID;

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge value of every other; the later write to a slot in the
    // same block wins, which lets an issue land on top of the shift.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            rr_ptr    <= '0;
            div_cnt   <= '0;
            RSP_VALID <= 1'b0;
            RSP_ID    <= '0;
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b0;
            // NOTE: the slot table is cleared on reset because its valid bits
            // are control state; a stale entry would emit a phantom response.
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                slots[k] <= slots[k+1];
            end
            slots[DEPTH-1] <= '0;

            if (grant_valid) begin
                // Entry for cycle t+L sits at offset L-1 after this shift.
                for (int k = 0; k < DEPTH; k++) begin
                    if (k == g_lat - 1) begin
                        slots[k] <= new_entry;
                    end
                end
                rr_ptr <= ID_W'((int'(grant_id) + 1) % REQ_COUNT);
            end

            if (grant_valid && g_op == OP_DIV) begin
                div_cnt <= DIV_W'(LAT_DIV - 1);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end

            RSP_VALID <= slots[0].valid;
            if (slots[0].valid) begin
                RSP_ID   <= slots[0].id;
                RSP_DATA <= res_sel;
                RSP_ERR  <= slots[0].err;
            end
        end
    end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// ============================================================================
// tb_fpu_op_scheduler
//
// Directed bench for fpu_op_scheduler. Simple unit models return
// unit-specific values exactly LAT cycles after U_EN; at every other cycle they
// return 0xDEAD0000. Expected responses are queued when stimulus is issued and
// a separate monitor pops and compares them whenever RSP_VALID is seen.
// Unit model values: ADD a^b, MUL a+b, DIV a-b, F2I ~a, I2F halfword swap.
// ============================================================================
module tb_fpu_op_scheduler;

    localparam int N       = 4;
    localparam int LAT_ADD = 3;
    localparam int LAT_MUL = 3;
    localparam int LAT_DIV = 12;
    localparam int LAT_CVT = 2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_F2I = 3'd4;
    localparam logic [2:0] OP_BAD = 3'd7;

    logic                 MCLK = 1'b0;
    logic                 RST;
    logic [N-1:0]         REQ_VALID;
    logic [N-1:0]         REQ_READY;
    logic [3*N-1:0]       REQ_OP;
    logic [32*N-1:0]      REQ_A;
    logic [32*N-1:0]      REQ_B;
    logic [4:0]           U_EN;
    logic [31:0]          U_A;
    logic [31:0]          U_B;
    logic [31:0]          U_RES_ADD;
    logic [31:0]          U_RES_MUL;
    logic [31:0]          U_RES_DIV;
    logic [31:0]          U_RES_F2I;
    logic [31:0]          U_RES_I2F;
    logic                 RSP_VALID;
    logic [$clog2(N)-1:0] RSP_ID;
    logic [31:0]          RSP_DATA;
    logic                 RSP_ERR;
    logic                 BUSY;

    fpu_op_scheduler #(
        .REQ_COUNT(N), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL),
        .LAT_DIV(LAT_DIV), .LAT_CVT(LAT_CVT)
    ) dut (
        .MCLK(MCLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .U_EN(U_EN), .U_A(U_A), .U_B(U_B),
        .U_RES_ADD(U_RES_ADD), .U_RES_MUL(U_RES_MUL), .U_RES_DIV(U_RES_DIV),
        .U_RES_F2I(U_RES_F2I), .U_RES_I2F(U_RES_I2F),
        .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
        .RSP_ERR(RSP_ERR), .BUSY(BUSY)
    );

    always #5 MCLK = ~MCLK;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge MCLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- unit models ----------------
    logic [31:0] add_due [int];
    logic [31:0] mul_due [int];
    logic [31:0] div_due [int];
    logic [31:0] f2i_due [int];
    logic [31:0] i2f_due [int];

    always @(negedge MCLK) begin
        if (U_EN[0]) add_due[cyc + LAT_ADD] = U_A ^ U_B;
        if (U_EN[1]) mul_due[cyc + LAT_MUL] = U_A + U_B;
        if (U_EN[2]) div_due[cyc + LAT_DIV] = U_A - U_B;
        if (U_EN[3]) f2i_due[cyc + LAT_CVT] = ~U_A;
        if (U_EN[4]) i2f_due[cyc + LAT_CVT] = {U_A[15:0], U_A[31:16]};
    end

    initial begin
        U_RES_ADD = 32'hDEAD0000;
        U_RES_MUL = 32'hDEAD0000;
        U_RES_DIV = 32'hDEAD0000;
        U_RES_F2I = 32'hDEAD0000;
        U_RES_I2F = 32'hDEAD0000;
        forever begin
            @(posedge MCLK);
            #1;
            U_RES_ADD = add_due.exists(cyc) ? add_due[cyc] : 32'hDEAD0000;
            U_RES_MUL = mul_due.exists(cyc) ? mul_due[cyc] : 32'hDEAD0000;
            U_RES_DIV = div_due.exists(cyc) ? div_due[cyc] : 32'hDEAD0000;
            U_RES_F2I = f2i_due.exists(cyc) ? f2i_due[cyc] : 32'hDEAD0000;
            U_RES_I2F = i2f_due.exists(cyc) ? i2f_due[cyc] : 32'hDEAD0000;
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        rsp_t e;
        forever begin
            @(negedge MCLK);
            if (RSP_VALID === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id %0d data 0x%08h at cycle %0d, required no response",
                             RSP_ID, RSP_DATA, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", cyc, e.cyc);
                    check("rsp_id", 32'(RSP_ID), e.id);
                    check("rsp_data", RSP_DATA, e.data);
                    check("rsp_err", 32'(RSP_ERR), 32'(e.err));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        REQ_VALID[i]      = v;
        REQ_OP[3*i +: 3]  = op;
        REQ_A[32*i +: 32] = a;
        REQ_B[32*i +: 32] = b;
    endtask

    task automatic expect_rsp(input int c, input int id, input logic [31:0] d, input logic e);
        rsp_t r;
        r.cyc  = c;
        r.id   = id;
        r.data = d;
        r.err  = e;
        exp_q.push_back(r);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((BUSY !== 1'b0 || exp_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got BUSY=%b pending=%0d, required idle", BUSY, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        RST       = 1'b1;
        REQ_VALID = '0;
        REQ_OP    = '0;
        REQ_A     = '0;
        REQ_B     = '0;
        step();
        step();

        // Issue-side outputs stay low while in reset even with requests present.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, OP_ADD, 32'h1, 32'h2);
        settle();
        check("ready_in_reset", 32'(REQ_READY), 32'h0);
        check("u_en_in_reset", 32'(U_EN), 32'h0);
        step();
        check("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
        check("rst_rsp_id", 32'(RSP_ID), 32'h0);
        check("rst_rsp_data", RSP_DATA, 32'h0);
        check("rst_rsp_err", 32'(RSP_ERR), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        REQ_VALID = '0;
        RST       = 1'b0;

        // ADD from requester 0.
        step();
        t = cyc;
        set_req(0, 1'b1, OP_ADD, 32'h3F800000, 32'h40000000);
        settle();
        check("add_ready", 32'(REQ_READY), 32'h1);
        check("add_u_en", 32'(U_EN), 32'h01);
        check("add_u_a", U_A, 32'h3F800000);
        check("add_u_b", U_B, 32'h40000000);
        expect_rsp(t + 4, 0, 32'h7F800000, 1'b0);
        step();
        set_req(0, 1'b0, OP_ADD, 32'h0, 32'h0);
        settle();
        check("add_busy_inflight", 32'(BUSY), 32'h1);
        while (cyc < t + 4) step();
        check("add_busy_rsp", 32'(BUSY), 32'h1);
        step();
        check("add_busy_done", 32'(BUSY), 32'h0);

        // SUB from requester 2: sign of B flipped on the ADD unit.
        step();
        t = cyc;
        set_req(2, 1'b1, OP_SUB, 32'h3F800000, 32'h40000000);
        settle();
        check("sub_ready", 32'(REQ_READY), 32'h4);
        check("sub_u_en", 32'(U_EN), 32'h01);
        check("sub_u_b", U_B, 32'hC0000000);
        expect_rsp(t + 4, 2, 32'hFF800000, 1'b0);
        step();
        set_req(2, 1'b0, OP_SUB, 32'h0, 32'h0);
        wait_idle();

        // Reset pulse returns the round-robin pointer to 0.
        RST = 1'b1;
        step();
        RST = 1'b0;

        // All four requesters hold ADD: grants 0..3, twice.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'b1, OP_ADD, 32'h10000000 * (r + 1) + i, 32'h000000FF);
            for (int g = 0; g < N; g++) begin
                settle();
                check("rr_ready", 32'(REQ_READY), 32'h1 << g);
                check("rr_u_a", U_A, 32'h10000000 * (r + 1) + g);
                expect_rsp(cyc + 4, g, (32'h10000000 * (r + 1) + g) ^ 32'h000000FF, 1'b0);
                step();
                REQ_VALID[g] = 1'b0;
            end
        end
        wait_idle();

        // MUL then F2I: the F2I completion slot collides for one cycle.
        t = cyc;
        set_req(0, 1'b1, OP_MUL, 32'h11111111, 32'h22222222);
        settle();
        check("mul_ready", 32'(REQ_READY), 32'h1);
        check("mul_u_en", 32'(U_EN), 32'h02);
        expect_rsp(t + 4, 0, 32'h33333333, 1'b0);
        step();
        set_req(0, 1'b0, OP_MUL, 32'h0, 32'h0);
        set_req(1, 1'b1, OP_F2I, 32'h0000FFFF, 32'h0);
        settle();
        check("f2i_blocked_ready", 32'(REQ_READY), 32'h0);
        check("f2i_blocked_u_en", 32'(U_EN), 32'h0);
        step();
        settle();
        check("f2i_ready", 32'(REQ_READY), 32'h2);
        check("f2i_u_en", 32'(U_EN), 32'h08);
        expect_rsp(t + 5, 1, 32'hFFFF0000, 1'b0);
        step();
        set_req(1, 1'b0, OP_F2I, 32'h0, 32'h0);
        wait_idle();

        // Back-to-back DIV: second waits for the divider; ADD is not blocked.
        t = cyc;
        expect_rsp(t + 5, 1, 32'hAAAAAAAA, 1'b0);
        expect_rsp(t + 13, 0, 32'h40000000, 1'b0);
        expect_rsp(t + 25, 0, 32'h50000000, 1'b0);
        set_req(0, 1'b1, OP_DIV, 32'h50000000, 32'h10000000);
        settle();
        check("div1_ready", 32'(REQ_READY), 32'h1);
        check("div1_u_en", 32'(U_EN), 32'h04);
        step();
        set_req(0, 1'b1, OP_DIV, 32'h70000000, 32'h20000000);
        set_req(1, 1'b1, OP_ADD, 32'hAAAA0000, 32'h0000AAAA);
        settle();
        check("div_skip_ready", 32'(REQ_READY), 32'h2);
        check("div_skip_u_en", 32'(U_EN), 32'h01);
        step();
        set_req(1, 1'b0, OP_ADD, 32'h0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            settle();
            check("div_blocked", 32'(REQ_READY), 32'h0);
            step();
        end
        settle();
        check("div2_cycle", cyc, t + 12);
        check("div2_ready", 32'(REQ_READY), 32'h1);
        check("div2_u_en", 32'(U_EN), 32'h04);
        step();
        set_req(0, 1'b0, OP_DIV, 32'h0, 32'h0);
        wait_idle();

        // Illegal opcode from requester 3.
        t = cyc;
        set_req(3, 1'b1, OP_BAD, 32'h1, 32'h2);
        settle();
        check("bad_ready", 32'(REQ_READY), 32'h8);
        check("bad_u_en", 32'(U_EN), 32'h0);
        expect_rsp(t + 2, 3, 32'h7FC00000, 1'b1);
        step();
        set_req(3, 1'b0, OP_ADD, 32'h0, 32'h0);
        wait_idle();

        // Reset while a MUL is in flight: no response, pointer back to 0.
        set_req(2, 1'b1, OP_MUL, 32'h5, 32'h6);
        settle();
        check("flush_mul_ready", 32'(REQ_READY), 32'h4);
        step();
        set_req(2, 1'b0, OP_MUL, 32'h0, 32'h0);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        settle();
        check("flush_busy", 32'(BUSY), 32'h0);
        check("flush_rsp_valid", 32'(RSP_VALID), 32'h0);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, OP_ADD, 32'hC0DE0000 + i, 32'h1);
        settle();
        check("flush_ptr_ready", 32'(REQ_READY), 32'h1);
        expect_rsp(cyc + 4, 0, 32'hC0DE0001, 1'b0);
        step();
        REQ_VALID = '0;
        wait_idle();
        for (int k = 0; k < 4; k++) step();
        check("queue_empty", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_op_scheduler.md
Name: fpu_op_scheduler

Overview:
- Shares one set of FPU execution units (F32 add, mul, div, F32-to-INT, INT-to-F32) among REQ_COUNT requesters.
- Arbitrates requests round-robin and issues at most one op per cycle.
- Reserves result-bus writeback slots so that no two units complete in the same cycle.
- Returns each result, tagged with the requester ID, on a single shared response port. It sits between the shader/ALU clients and the FPU unit wrappers.

Parameters:
- REQ_COUNT, 4, number of requesters (2..8)
- LAT_ADD, 3, add/sub unit latency in cycles, pipelined
- LAT_MUL, 3, multiply unit latency, pipelined
- LAT_DIV, 12, divide unit latency, NOT pipelined
- LAT_CVT, 2, F2I and I2F unit latency, pipelined

Ports:
- MCLK  in  1  clock
- RST  in  1  reset
- REQ_VALID  in  REQ_COUNT  per-requester request valid
- REQ_READY  out  REQ_COUNT  per-requester accept; combinational, one-hot or zero
- REQ_OP  in  3*REQ_COUNT  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 F2I, 5 I2F, 6/7 illegal
- REQ_A  in  32*REQ_COUNT  operand A
- REQ_B  in  32*REQ_COUNT  operand B
- U_EN  out  5  one-hot unit issue strobe: bit0 ADD, 1 MUL, 2 DIV, 3 F2I, 4 I2F
- U_A  out  32  issued operand A
- U_B  out  32  issued operand B
- U_RES_ADD, U_RES_MUL, U_RES_DIV, U_RES_F2I, U_RES_I2F  in  32 each  unit result outputs
- RSP_VALID  out  1  response valid, one-cycle pulse
- RSP_ID  out  clog2(REQ_COUNT)  requester index
- RSP_DATA  out  32  result
- RSP_ERR  out  1  illegal-opcode flag
- BUSY  out  1  ops in flight

Behaviour:
- Single clock MCLK; reset RST is synchronous, active-high.
- Reset values: RSP_VALID=0, RSP_ID=0, RSP_DATA=0, RSP_ERR=0, BUSY=0; RR pointer=0; slot table clear; div counter=0.
- Outputs U_EN, U_A, U_B and REQ_READY are combinational and are 0 while RST=1.
- Latency L per op: ADD/SUB=LAT_ADD, MUL=LAT_MUL, DIV=LAT_DIV, F2I/I2F=LAT_CVT, illegal=1.
- Issuability: a request is issuable in cycle t when slot t+L is unreserved. DIV additionally requires div_cnt==0.
- Arbitration:
  - Scan requesters starting at the RR pointer.
  - Grant the first one with VALID set that is issuable. Non-issuable requesters are skipped (no head-of-line blocking).
  - On a grant, REQ_READY[g]=1 and the pointer becomes (g+1) mod REQ_COUNT. With no grant, the pointer holds.
  - REQ_READY may depend on REQ_VALID.
  - A requester must hold its VALID and operands stable until READY.
- Issue in cycle t:
  - U_EN = one-hot unit for the granted op; U_A = REQ_A[g].
  - U_B = REQ_B[g], except SUB, which drives U_B with bit 31 inverted on the ADD unit.
  - Illegal ops drive U_EN=0.
  - A slot entry {valid, id, unit, err} is reserved for cycle t+L.
- Slot table:
  - Depth = max latency.
  - Shifts one position per cycle.
  - An issue and the shift occur in the same cycle without loss.
- Writeback:
  - In cycle t+L the scheduler samples the selected U_RES_x (illegal ops use 0x7FC00000).
  - It registers RSP_VALID/ID/DATA/ERR, visible in cycle t+L+1 for exactly one cycle.
  - There is no backpressure on the response port.
- Divider counter:
  - div_cnt is loaded with LAT_DIV-1 on DIV issue and decrements to 0.
  - The next DIV is issuable at t+LAT_DIV.
- Ordering: responses from the same requester may return out of order when latencies differ. Clients use the returned ID.
- BUSY = any slot valid OR div_cnt!=0 OR RSP_VALID.
- Reset mid-operation: all in-flight entries are discarded, no RSP is produced for them, and units are assumed to be flushed by the same RST.

Test Plan:
- req0 ADD A=0x3F800000 B=0x40000000 at cycle 0, U_RES_ADD=0x40400000 at cycle 3 -> U_EN=5'b00001 at cycle 0; RSP_VALID at cycle 4, ID=0, DATA=0x40400000, ERR=0; BUSY low at cycle 5.
- req2 SUB B=0x40000000 -> U_EN bit0, U_B=0xC0000000; RSP ID=2 at t+4.
- All 4 requesters hold ADD valid from cycle 0 -> grants 0,1,2,3 at cycles 0..3; RSPs at cycles 4..7 with IDs 0,1,2,3; then round-robin repeats.
- req0 MUL at t, req1 F2I valid from t+1 -> req1 READY=0 at t+1 (slot t+3 taken), granted at t+2; RSPs at t+4 (ID0) and t+5 (ID1).
- req0 DIV at t and again at t+1, req1 ADD at t+1 -> req1 granted at t+1; second DIV granted at t+12; RSPs at t+13 and t+25.
- req3 opcode 7 -> U_EN=0, RSP at t+2 with ERR=1, DATA=0x7FC00000, ID=3.
- Issue a MUL then assert RST at t+2 for 1 cycle -> no RSP_VALID afterwards; BUSY=0 and pointer=0 after reset.
